// File: rtl/viterbi_chan_pkg.sv
// Shared types and helpers for the soft-bit channel stage between conv_encoder and viterbi_dec.
package viterbi_chan_pkg;

    localparam int DEF_SOFT_W = 3;

    typedef logic [DEF_SOFT_W-1:0] soft_t;

    localparam soft_t       SOFT_MAX  = soft_t'((1 << DEF_SOFT_W) - 1);
    // Galois feedback mask for x^16+x^14+x^13+x^11, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int sat_soft(input int v, input int maxv);
        if (v < 0) return 0;
        if (v > maxv) return maxv;
        return v;
    endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 16-bit Galois LFSR noise source; steps on en, reloads seed on load (load wins).
module chan_lfsr
    import viterbi_chan_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/soft_bit_channel.sv
// Soft-bit channel: maps rate-1/2 coded pairs to offset-binary soft words through one register stage.
// Define SOFT_BIT_CHANNEL_NOISE_EN to build the LFSR noise adder and hard-decision flip counter.
module soft_bit_channel
    import viterbi_chan_pkg::*;
#(
    parameter int          SOFT_W    = DEF_SOFT_W,
    parameter int          NOISE_W   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [7:0]       in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [7:0]       out_tdata,
    input  logic             noise_en,
    input  logic [1:0]       noise_shift,
    input  logic             flip_clr,
    output logic [CNT_W-1:0] flip_count
);

    localparam int SOFT_MAX_I = (1 << SOFT_W) - 1;

    logic              accept;
    logic [SOFT_W-1:0] base1, base0, soft1, soft0;
    logic              unusedData;

    assign in_tready  = !out_tvalid || out_tready;
    assign accept     = in_tvalid && in_tready;
    assign base1      = in_tdata[1] ? SOFT_W'(SOFT_MAX_I) : '0;
    assign base0      = in_tdata[0] ? SOFT_W'(SOFT_MAX_I) : '0;
    assign unusedData = ^in_tdata[7:2];

`ifdef SOFT_BIT_CHANNEL_NOISE_EN
    localparam int SUM_W = SOFT_W + NOISE_W + 1;

    logic [15:0]               lfsr;
    logic signed [NOISE_W-1:0] n1, n0;
    logic signed [SUM_W-1:0]   sum1, sum0;
    logic                      flip;
    logic [CNT_W-1:0]          flipCount;

    chan_lfsr #(.SEED(LFSR_SEED)) uLfsr (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .en    (accept),
        .load  (flip_clr),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign n1 = $signed(lfsr[15 -: NOISE_W]) >>> noise_shift;
    assign n0 = $signed(lfsr[NOISE_W-1:0]) >>> noise_shift;

    // Widened signed sum so clamping sees the true value before truncation
    always_comb begin
        sum1 = {{(NOISE_W+1){1'b0}}, base1};
        sum0 = {{(NOISE_W+1){1'b0}}, base0};
        if (noise_en) begin
            sum1 = sum1 + {{(SUM_W-NOISE_W){n1[NOISE_W-1]}}, n1};
            sum0 = sum0 + {{(SUM_W-NOISE_W){n0[NOISE_W-1]}}, n0};
        end
        soft1 = SOFT_W'(sat_soft(int'(sum1), SOFT_MAX_I));
        soft0 = SOFT_W'(sat_soft(int'(sum0), SOFT_MAX_I));
    end

    assign flip = (soft1[SOFT_W-1] != in_tdata[1]) || (soft0[SOFT_W-1] != in_tdata[0]);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            flipCount <= '0;
        end else if (flip_clr) begin
            flipCount <= '0;
        end else if (accept && flip && (flipCount != '1)) begin
            flipCount <= flipCount + 1'b1;
        end
    end

    assign flip_count = flipCount;
`else
    logic unusedNoise;

    assign soft1       = base1;
    assign soft0       = base0;
    assign flip_count  = '0;
    assign unusedNoise = ^{noise_en, noise_shift, flip_clr, LFSR_SEED, 32'(NOISE_W)};
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else if (accept) begin
            out_tvalid <= 1'b1;
            out_tdata  <= 8'({soft1, soft0});
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_soft_bit_channel.sv
// Randomized bench for soft_bit_channel against a spec-level reference model and transfer scoreboard.
module tb_soft_bit_channel;

    localparam int          SOFT_W  = 3;
    localparam int          NOISE_W = 4;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          CNT_W   = 6;
    localparam int          MAXV    = (1 << SOFT_W) - 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef SOFT_BIT_CHANNEL_NOISE_EN
    localparam bit NB = 1'b1;
`else
    localparam bit NB = 1'b0;
`endif

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic [7:0]       in_tdata = '0;
    logic             out_tvalid;
    logic             out_tready = 1'b1;
    logic [7:0]       out_tdata;
    logic             noise_en = 1'b0;
    logic [1:0]       noise_shift = '0;
    logic             flip_clr = 1'b0;
    logic [CNT_W-1:0] flip_count;

    int tests = 0;
    int fails = 0;

    soft_bit_channel #(.SOFT_W(SOFT_W), .NOISE_W(NOISE_W), .LFSR_SEED(SEED), .CNT_W(CNT_W)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .in_tdata    (in_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_tdata   (out_tdata),
        .noise_en    (noise_en),
        .noise_shift (noise_shift),
        .flip_clr    (flip_clr),
        .flip_count  (flip_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level soft mapping: offset-binary base plus attenuated signed noise, clamped
    function automatic logic [7:0] expWord(input logic [1:0] c, input logic ne, input logic [1:0] sh,
                                           input int lf, output bit fl);
        int s [2];
        int field, n, v;
        fl = 1'b0;
        for (int i = 0; i < 2; i++) begin
            field = (i == 1) ? ((lf >> (16 - NOISE_W)) & ((1 << NOISE_W) - 1)) : (lf & ((1 << NOISE_W) - 1));
            n = (field >= (1 << (NOISE_W - 1))) ? field - (1 << NOISE_W) : field;
            n = n >>> sh;
            v = (c[i] ? MAXV : 0) + ((NB && ne) ? n : 0);
            if (v < 0) v = 0;
            if (v > MAXV) v = MAXV;
            s[i] = v;
            if (((v >> (SOFT_W - 1)) & 1) != int'(c[i])) fl = 1'b1;
        end
        return 8'((s[1] << SOFT_W) | s[0]);
    endfunction

    // Reference model state
    bit         mValid;
    logic [7:0] mData;
    int         mLfsr, mCnt, accCnt, xferCnt;
    bit         mAcc, mFl;
    logic [7:0] mW;
    logic [7:0] sbq [$];

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mValid = 1'b0;
            mData  = '0;
            mCnt   = 0;
            mLfsr  = int'(SEED);
            sbq.delete();
        end else begin
            mAcc = in_tvalid && (!mValid || out_tready);
            mW   = expWord(in_tdata[1:0], noise_en, noise_shift, mLfsr, mFl);
            if (NB) begin
                if (flip_clr) mCnt = 0;
                else if (mAcc && mFl && noise_en && mCnt < CNT_MAX) mCnt++;
                if (flip_clr) mLfsr = int'(SEED);
                else if (mAcc) mLfsr = (mLfsr >> 1) ^ (((mLfsr & 1) != 0) ? 32'hB400 : 32'h0);
            end
            if (mAcc) begin
                mValid = 1'b1;
                mData  = mW;
                accCnt++;
                sbq.push_back(mW);
            end else if (out_tready) begin
                mValid = 1'b0;
            end
        end
    end

    // Compare process: every cycle out of reset, plus in-order transfer scoreboard
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            chk("out_tvalid", 32'(out_tvalid), 32'(mValid));
            chk("in_tready", 32'(in_tready), 32'(!mValid || out_tready));
            chk("flip_count", 32'(flip_count), 32'(mCnt));
            if (mValid) chk("out_tdata", 32'(out_tdata), 32'(mData));
            if (out_tvalid && out_tready) begin
                xferCnt++;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL xfer_dup: transfer of %0h with no pending beat at %0t", out_tdata, $time);
                end else begin
                    chk("xfer_data", 32'(out_tdata), 32'(sbq.pop_front()));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    // mode: 0 noise off, 1 noise on, 2 random noise_en
    task automatic runRandom(input int beats, input int mode, input bit randShift, input bit randClr,
                             input int stallPct);
        int start = accCnt;
        int cycles = 0;
        while ((accCnt - start) < beats && cycles < beats * 8) begin
            in_tvalid   = ($urandom % 100) < 80;
            in_tdata    = 8'($urandom);
            out_tready  = int'($urandom % 100) >= stallPct;
            noise_en    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
            noise_shift = randShift ? 2'($urandom) : 2'd0;
            flip_clr    = randClr && ($urandom % 50 == 0);
            cyc();
            cycles++;
        end
        chk("beat_budget", 32'((accCnt - start) >= beats), 32'd1);
        in_tvalid  = 1'b0;
        flip_clr   = 1'b0;
        out_tready = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] lit1 [4];
        lit1 = '{8'h00, 8'h07, 8'h38, 8'h3F};

        // Reset state
        cyc();
        cyc();
        chk("rst_valid", 32'(out_tvalid), 32'd0);
        chk("rst_data", 32'(out_tdata), 32'd0);
        chk("rst_cnt", 32'(flip_count), 32'd0);
        chk("rst_ready", 32'(in_tready), 32'd1);
        ap_rst_n = 1'b1;
        cyc();

        // Clean mapping, back-to-back
        in_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_tdata = 8'(i) | 8'hA4;
            cyc();
            chk("map_lit", 32'(out_tdata), 32'(lit1[i]));
        end
        in_tvalid = 1'b0;
        cyc();

        // Backpressure hold and single transfer
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = 8'h01;
        cyc();
        in_tdata = 8'h02;
        cyc();
        chk("hold_valid", 32'(out_tvalid), 32'd1);
        chk("hold_data", 32'(out_tdata), 32'h07);
        chk("hold_ready", 32'(in_tready), 32'd0);
        out_tready = 1'b1;
        cyc();
        chk("bp_next", 32'(out_tdata), 32'h38);
        out_tready = 1'b0;
        in_tvalid  = 1'b0;
        cyc();
        chk("bp_held", 32'(out_tvalid), 32'd1);
        out_tready = 1'b1;
        cyc();
        chk("bp_drain", 32'(out_tvalid), 32'd0);

        runRandom(1000, 0, 1'b0, 1'b0, 40);

        // Noisy run from a fresh seed
        flip_clr = 1'b1;
        cyc();
        flip_clr = 1'b0;
        runRandom(4096, 1, 1'b0, 1'b0, 10);
        if (NB) chk("cnt_sat", 32'(flip_count), 32'(CNT_MAX));

        runRandom(1000, 2, 1'b1, 1'b1, 40);

        // Clear coinciding with an accepted noisy beat
        noise_en   = 1'b1;
        in_tvalid  = 1'b1;
        in_tdata   = 8'h03;
        flip_clr   = 1'b1;
        out_tready = 1'b1;
        cyc();
        flip_clr  = 1'b0;
        in_tvalid = 1'b0;
        chk("clr_cnt", 32'(flip_count), 32'd0);
`ifdef SOFT_BIT_CHANNEL_NOISE_EN
        chk("clr_lfsr", 32'(dut.uLfsr.state), 32'(SEED));
`endif
        cyc();

        // Async reset while a beat is held
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = 8'h03;
        cyc();
        in_tvalid = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_tvalid), 32'd0);
        chk("arst_cnt", 32'(flip_count), 32'd0);
        cyc();
        ap_rst_n   = 1'b1;
        noise_en   = 1'b0;
        out_tready = 1'b1;
        in_tvalid  = 1'b1;
        in_tdata   = 8'h02;
        cyc();
        chk("post_rst", 32'(out_tdata), 32'h38);
        in_tvalid = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
